ser_gearbox: RTL
================

# ser_gearbox

Parametrised multi-channel parallel-to-serial gearbox in fabric logic. It takes IN_W-bit words per channel through a valid/ready handshake and emits OUT_W bits per channel every clock, LSB first. It generalises the fixed 10:1 primitive serializer to arbitrary width ratios and channel counts, and adds:

- a one-word input buffer,
- pattern/idle insertion,
- underflow reporting,
- a word-boundary marker for downstream alignment.

It sits between the pixel/encoder pipeline and the output pins or primitive serializers.

## Interface

Parameters:
- CHANNELS, 3, number of lanes serialised in lockstep
- IN_W, 10, input word width per channel
- OUT_W, 2, output slice width per channel; IN_W % OUT_W == 0 (elaboration error otherwise); R = IN_W/OUT_W ≥ 2

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  gearbox accepts word this cycle
- in_data  in  CHANNELS*IN_W  channel c at [c*IN_W +: IN_W]
- pattern_en  in  1  force fill pattern at load points
- pattern  in  IN_W  fill word, all channels
- clear_status  in  1  clears underflow
- out_data  out  CHANNELS*OUT_W  channel c at [c*OUT_W +: OUT_W]; bit 0 is earliest in time
- word_start  out  1  high while out_data carries slice 0 of a word
- underflow  out  1  sticky underflow flag

## Operation

- State:
  - phase counter, 0..R-1
  - per-channel shift register, IN_W bits
  - buffer: buf_valid, buf_data (CHANNELS*IN_W)
  - running flag
  - out_data, word_start, underflow registers
- Load point: the edge where phase == R-1. Phase then wraps to 0; otherwise phase increments.
- At a load point, word W is selected:
  - pattern_en = 1: W = pattern on every channel; buffer untouched.
  - else if buf_valid: W = buf_data; buffer consumed; running ← 1.
  - else: W = pattern. If running = 1, underflow ← 1.
- Load edge action:
  - out_data_c ← W_c[OUT_W-1:0]
  - shreg_c ← W_c >> OUT_W
  - word_start ← 1
- Non-load edge action:
  - out_data_c ← shreg_c[OUT_W-1:0]
  - shreg_c ← shreg_c >> OUT_W
  - word_start ← 0
- Handshake:
  - consume = load point & !pattern_en & buf_valid.
  - in_ready = !reset & (!buf_valid | consume).
  - Accept on in_valid & in_ready: buf_data ← in_data, buf_valid ← 1.
  - Otherwise buf_valid ← buf_valid & !consume.
  - Simultaneous consume and accept: the buffer is replaced, so no bubble occurs.
- Status:
  - underflow clears on reset or clear_status.
  - clear_status and a new underflow in the same cycle: set wins.

## Timing

- Reset values:
  - phase = R-1, so the first edge after reset is a load point
  - shreg = 0, out_data = 0, word_start = 0
  - buf_valid = 0, running = 0, underflow = 0
  - in_ready = 0 while reset is asserted
- Latency, best case: word accepted at edge t is in the buffer from t+1 and is loaded at the first load point ≥ t+1. Its slice k appears on out_data in the k-th cycle after that load edge, counting from 0.
- Throughput: one word per R cycles sustained. in_valid may be held continuously.
- Reset mid-word: the partial word is discarded and the buffer is flushed. out_data reads 0 for the first cycle after reset deasserts, then the pattern until data arrives.
- pattern_en change: sampled only at load points. A word in flight always completes all R slices.
- Underflow is never flagged before the first real word (running = 0).

## Structure

- Package ser_gearbox_pkg:
  - function ratio(IN_W, OUT_W)
  - function clog2-based phase width
  - localparam for default TMDS-style sizes (IN_W = 10)
- Sub-module ser_lane: one channel's shift register and out_data slice, driven by shared load strobe and selected word.
- Top level owns phase, buffer, handshake and status.
- Instantiate CHANNELS lanes via generate.

## Test plan

1. Reset, defaults: hold reset 3 cycles -> in_ready = 0, out_data = 0, word_start = 0, underflow = 0. Release with pattern = 0 and nothing offered -> out_data stays 0, underflow stays 0.
2. Single word: channel 0 = 0x1E4, others 0 -> channel 0 slices 0,1,2,3,1 on consecutive cycles; word_start high with slice 0 only; other channels 0.
3. Back-to-back: 8 words, in_valid held -> in_ready pulses once per 5 cycles, output contiguous with no fill, underflow = 0.
4. Underflow: send one word then stop, pattern = 0x155 -> 0x155 slices follow immediately, underflow = 1 and sticky. clear_status -> underflow = 0, then back to 1 on the next empty load point.
5. Pattern override: buffer full, pattern_en asserted mid-word -> current word completes, then pattern words. Buffered word waits (in_ready = 0) and emerges intact after pattern_en drops.
6. Reset mid-word: reset at slice 2 with buffer full -> next cycle all outputs at reset values. After release, the old data never appears.

Source files
------------

// File: rtl/ser_gearbox_pkg.sv
// ser_gearbox_pkg
//   Shared sizing helpers and default TMDS-style sizes for the parallel-to-serial
//   gearbox. Imported by ser_gearbox (top) and ser_lane (per-channel slice).
//
//   ratio()       : number of OUT_W slices per IN_W word (R = IN_W / OUT_W)
//   phase_width() : bits needed for a phase counter that runs 0..R-1
package ser_gearbox_pkg;

  // Default sizes match a three-lane 10-bit TMDS link serialised 2 bits/clock.
  localparam int TMDS_CHANNELS = 3;
  localparam int TMDS_IN_W     = 10;
  localparam int TMDS_OUT_W    = 2;

  // Slices per word.
  function automatic int ratio(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  // Width of a counter spanning 0..r-1; never narrower than one bit.
  function automatic int phase_width(input int r);
    return (r <= 2) ? 1 : $clog2(r);
  endfunction

endpackage

// File: rtl/ser_lane.sv
// ser_lane
//   One channel of the gearbox: an IN_W-bit shift register that is reloaded
//   with the selected word at each load point and otherwise shifts right by
//   OUT_W bits, plus the registered OUT_W-bit output slice (LSB first).
//
//   Ports:
//     clk      in   clock
//     reset    in   synchronous active-high reset
//     load_i   in   shared load strobe (phase == R-1)
//     word_i   in   word selected by the top for this channel
//     slice_o  out  registered output slice for this channel
module ser_lane
  import ser_gearbox_pkg::*;
#(
  parameter int IN_W  = TMDS_IN_W,
  parameter int OUT_W = TMDS_OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [IN_W-1:0]  word_i,
  output logic [OUT_W-1:0] slice_o
);

  logic [IN_W-1:0]  shreg_q;
  logic [IN_W-1:0]  shreg_d;
  logic [OUT_W-1:0] slice_q;
  logic [OUT_W-1:0] slice_d;

  // Next slice/shift state: slice 0 comes straight from the new word so the
  // shift register only needs to hold the remaining R-1 slices.
  always_comb begin
    shreg_d = shreg_q;
    slice_d = slice_q;
    if (load_i) begin
      slice_d = word_i[OUT_W-1:0];
      shreg_d = word_i >> OUT_W;
    end else begin
      slice_d = shreg_q[OUT_W-1:0];
      shreg_d = shreg_q >> OUT_W;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= {IN_W{1'b0}};
      slice_q <= {OUT_W{1'b0}};
    end else begin
      shreg_q <= shreg_d;
      slice_q <= slice_d;
    end
  end

  assign slice_o = slice_q;

endmodule

// File: rtl/ser_gearbox.sv
// ser_gearbox
//   Multi-channel parallel-to-serial gearbox. Accepts CHANNELS x IN_W-bit words
//   over valid/ready into a one-word buffer and emits OUT_W bits per channel
//   every clock, LSB first. At each load point (phase == R-1) a new word is
//   taken from the buffer, or the fill pattern is inserted when pattern_en is
//   set or the buffer is empty. Running dry after the first real word raises a
//   sticky underflow flag.
//
//   Ports:
//     clk           in   sole clock
//     reset         in   synchronous active-high reset
//     in_valid      in   input word valid
//     in_ready      out  word accepted this cycle when in_valid is also high
//     in_data       in   CHANNELS*IN_W, channel c at [c*IN_W +: IN_W]
//     pattern_en    in   force fill pattern at load points
//     pattern       in   IN_W fill word, used on every channel
//     clear_status  in   clears underflow (a simultaneous new underflow wins)
//     out_data      out  CHANNELS*OUT_W, channel c at [c*OUT_W +: OUT_W]
//     word_start    out  high while out_data carries slice 0 of a word
//     underflow     out  sticky underflow flag
module ser_gearbox
  import ser_gearbox_pkg::*;
#(
  parameter int CHANNELS = TMDS_CHANNELS,
  parameter int IN_W     = TMDS_IN_W,
  parameter int OUT_W    = TMDS_OUT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*IN_W-1:0]  in_data,
  input  logic                      pattern_en,
  input  logic [IN_W-1:0]           pattern,
  input  logic                      clear_status,
  output logic [CHANNELS*OUT_W-1:0] out_data,
  output logic                      word_start,
  output logic                      underflow
);

  localparam int R  = ratio(IN_W, OUT_W);
  localparam int PW = phase_width(R);
  localparam logic [PW-1:0] LAST_PHASE = PW'(R - 1);

  // Reject width combinations that do not divide into at least two slices.
  if (((IN_W % OUT_W) != 0) || (R < 2)) begin : g_bad_ratio
    $error("ser_gearbox: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
  end

  logic [PW-1:0]            phase_q;
  logic [PW-1:0]            phase_d;
  logic                     buf_valid_q;
  logic                     buf_valid_d;
  logic [CHANNELS*IN_W-1:0] buf_data_q;
  logic [CHANNELS*IN_W-1:0] buf_data_d;
  logic                     running_q;
  logic                     running_d;
  logic                     underflow_q;
  logic                     underflow_d;
  logic                     word_start_q;
  logic                     word_start_d;

  logic load_s;
  logic consume_s;
  logic accept_s;
  logic in_ready_s;
  logic use_pattern_s;
  logic underflow_set_s;

  // Load-point decode, handshake and word-source selection.
  always_comb begin
    load_s          = (phase_q == LAST_PHASE);
    consume_s       = load_s & ~pattern_en & buf_valid_q;
    // Ready also when the buffered word leaves this edge, so a held in_valid
    // refills the buffer without a bubble.
    in_ready_s      = ~reset & (~buf_valid_q | consume_s);
    accept_s        = in_valid & in_ready_s;
    use_pattern_s   = pattern_en | ~buf_valid_q;
    // Only an empty buffer counts as underflow; a forced pattern does not.
    underflow_set_s = load_s & ~pattern_en & ~buf_valid_q & running_q;
  end

  // Next-state for phase, buffer and status.
  always_comb begin
    phase_d      = phase_q;
    buf_valid_d  = buf_valid_q;
    buf_data_d   = buf_data_q;
    running_d    = running_q | consume_s;
    underflow_d  = underflow_q;
    word_start_d = load_s;

    if (load_s) begin
      phase_d = {PW{1'b0}};
    end else begin
      phase_d = phase_q + PW'(1);
    end

    if (accept_s) begin
      buf_valid_d = 1'b1;
      buf_data_d  = in_data;
    end else if (consume_s) begin
      buf_valid_d = 1'b0;
    end else begin
      buf_valid_d = buf_valid_q;
    end

    // Set has priority over clear so a fresh underflow is never lost.
    if (underflow_set_s) begin
      underflow_d = 1'b1;
    end else if (clear_status) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // Control and status registers; phase resets to R-1 so the first edge loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= LAST_PHASE;
      buf_valid_q  <= 1'b0;
      buf_data_q   <= {(CHANNELS*IN_W){1'b0}};
      running_q    <= 1'b0;
      underflow_q  <= 1'b0;
      word_start_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      buf_valid_q  <= buf_valid_d;
      buf_data_q   <= buf_data_d;
      running_q    <= running_d;
      underflow_q  <= underflow_d;
      word_start_q <= word_start_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic [IN_W-1:0] lane_word_s;

    // Per-lane word mux: fill pattern or this channel's buffered word.
    always_comb begin
      if (use_pattern_s) begin
        lane_word_s = pattern;
      end else begin
        lane_word_s = buf_data_q[c*IN_W +: IN_W];
      end
    end

    ser_lane #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .load_i  (load_s),
      .word_i  (lane_word_s),
      .slice_o (out_data[c*OUT_W +: OUT_W])
    );
  end

  assign in_ready   = in_ready_s;
  assign word_start = word_start_q;
  assign underflow  = underflow_q;

endmodule
